// File: rtl/cpu_debug_display_pkg.sv
// cpu_dbg_pkg: shared page indices, blank pattern and seven-segment hex font
package cpu_dbg_pkg;
  localparam logic [1:0] PAGE_PC_OP = 2'd0;
  localparam logic [1:0] PAGE_IN1 = 2'd1;
  localparam logic [1:0] PAGE_IN2 = 2'd2;
  localparam logic [1:0] PAGE_RES = 2'd3;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    return HEX_FONT[v];
  endfunction
endpackage

// File: rtl/cpu_debug_display_if.sv
// cpu_debug_display_if: core observation buses, write-back strobe and step clock
interface cpu_debug_display_if;
  logic wb_clk;
  logic [5:0] opcode;
  logic [31:0] pc_out;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_result;
  logic cpu_clk;
  modport master(output wb_clk, opcode, pc_out, alu_in1, alu_in2, alu_result, input cpu_clk);
  modport slave(input wb_clk, opcode, pc_out, alu_in1, alu_in2, alu_result, output cpu_clk);
endinterface

// File: rtl/cpu_debug_display_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter and one-cycle press pulse
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int W = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  logic [1:0] sync;
  logic level;
  logic [W-1:0] cnt;
  logic hit;
  assign hit = cnt == W'(DEB_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      level <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      press <= sync[1] & ~level & hit;
      cnt <= (sync[1] == level || hit) ? '0 : cnt + 1'b1;
      level <= (sync[1] != level && hit) ? sync[1] : level;
    end
endmodule

// File: rtl/cpu_debug_display.sv
// cpu_debug_display: single-step clock generator and paged seven-segment view of core buses
module cpu_debug_display
  import cpu_dbg_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DEB_CYCLES = 1000000,
  parameter int STEP_HIGH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_step,
  input  logic btn_page,
  cpu_debug_display_if.slave dbg,
  output logic [1:0] page,
  output logic [3:0] an,
  output logic [7:0] seg
);
  localparam int SW = STEP_HIGH > 1 ? $clog2(STEP_HIGH) : 1;
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic step_press, page_press;
  logic cpu_clk_q;
  logic [SW-1:0] step_cnt;
  logic [2:0] wb_s;
  logic wb_edge;
  logic [15:0] snap [4];
  logic [15:0] disp;
  logic [DW-1:0] div;
  logic [1:0] d;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (.clk(clk), .rst_n(rst_n), .btn(btn_step), .press(step_press));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_page (.clk(clk), .rst_n(rst_n), .btn(btn_page), .press(page_press));
  assign dbg.cpu_clk = cpu_clk_q;
  assign wb_edge = wb_s[1] & ~wb_s[2];
  assign disp = snap[page];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cpu_clk_q <= 1'b0;
      step_cnt <= '0;
    end else begin
      cpu_clk_q <= cpu_clk_q ? step_cnt != SW'(STEP_HIGH - 1) : step_press;
      step_cnt <= cpu_clk_q ? step_cnt + 1'b1 : '0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      page <= PAGE_PC_OP;
      wb_s <= '0;
      snap <= '{default: '0};
    end else begin
      page <= page + {1'b0, page_press};
      wb_s <= {wb_s[1:0], dbg.wb_clk};
      if (wb_edge) begin
        snap[PAGE_PC_OP] <= {2'b00, dbg.opcode, dbg.pc_out[7:0]};
        snap[PAGE_IN1] <= dbg.alu_in1[15:0];
        snap[PAGE_IN2] <= dbg.alu_in2[15:0];
        snap[PAGE_RES] <= dbg.alu_result[15:0];
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div <= '0;
      d <= '0;
      an <= 4'hF;
      seg <= SEG_BLANK;
    end else begin
      div <= (div == DW'(SCAN_DIV - 1)) ? '0 : div + 1'b1;
      d <= (div == DW'(SCAN_DIV - 1)) ? d + 1'b1 : d;
      an <= ~(4'b0001 << d);
      seg <= {d != page, hex_seg(disp[{d, 2'b00} +: 4])};
    end
endmodule

// File: tb/tb_cpu_debug_display.sv
// tb_cpu_debug_display: randomized self-checking bench against a behavioural display/step model
module tb_cpu_debug_display;
  localparam int SD = 4;
  localparam int DB = 8;
  localparam int SH = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_step = 1'b0;
  logic btn_page = 1'b0;
  logic [1:0] page;
  logic [3:0] an;
  logic [7:0] seg;
  int checks = 0;
  int errors = 0;
  int n_pulses = 0;
  int last_w = 0;
  int hi_run = 0;
  logic [1:0] page_m;
  logic [5:0] op_m;
  logic [31:0] pc_m, in1_m, in2_m, res_m;
  cpu_debug_display_if bus();
  cpu_debug_display #(.SCAN_DIV(SD), .DEB_CYCLES(DB), .STEP_HIGH(SH)) dut (
    .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .btn_page(btn_page),
    .dbg(bus), .page(page), .an(an), .seg(seg)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst_n) hi_run = 0;
    else if (bus.cpu_clk) hi_run++;
    else if (hi_run > 0) begin
      n_pulses++;
      last_w = hi_run;
      hi_run = 0;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction
  function automatic logic [15:0] disp_m();
    case (page_m)
      2'd0: return {2'b00, op_m, pc_m[7:0]};
      2'd1: return in1_m[15:0];
      2'd2: return in2_m[15:0];
      default: return res_m[15:0];
    endcase
  endfunction
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic model_reset();
    page_m = 2'd0; op_m = '0; pc_m = '0; in1_m = '0; in2_m = '0; res_m = '0;
  endtask
  task automatic rand_bus();
    bus.opcode = 6'($urandom);
    bus.pc_out = $urandom;
    bus.alu_in1 = $urandom;
    bus.alu_in2 = $urandom;
    bus.alu_result = $urandom;
  endtask
  task automatic wb_pulse();
    bus.wb_clk = 1'b1;
    op_m = bus.opcode; pc_m = bus.pc_out; in1_m = bus.alu_in1; in2_m = bus.alu_in2; res_m = bus.alu_result;
    cycles(4);
    bus.wb_clk = 1'b0;
    cycles(4);
  endtask
  task automatic page_press();
    btn_page = 1'b1;
    cycles(14);
    btn_page = 1'b0;
    cycles(14);
    page_m = page_m + 2'd1;
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_cpu_clk"}, 32'(bus.cpu_clk), 0);
    chk({tag, "_page"}, 32'(page), 0);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'hFF);
  endtask
  task automatic scan_check(input int n);
    int d, z;
    logic [15:0] v;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      z = 0;
      d = 0;
      for (int b = 0; b < 4; b++) if (!an[b]) begin z++; d = b; end
      v = disp_m();
      chk("an_onehot", 32'(z), 1);
      chk("seg", 32'(seg), 32'({(d == int'(page_m)) ? 1'b0 : 1'b1, font(v[d*4 +: 4])}));
      chk("page", 32'(page), 32'(page_m));
    end
  endtask
  initial begin
    int n0, t;
    bus.wb_clk = 1'b0;
    rand_bus();
    model_reset();
    repeat (6) begin
      @(negedge clk);
      rand_bus();
      bus.wb_clk = 1'($urandom);
      btn_step = 1'($urandom);
      btn_page = 1'($urandom);
      chk_reset_state("rst");
    end
    @(negedge clk);
    bus.wb_clk = 1'b0;
    btn_step = 1'b0;
    btn_page = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] e;
      @(negedge clk);
      e = ~(4'b0001 << ((i / 4) % 4));
      chk("scan_an", 32'(an), 32'(e));
    end
    scan_check(16);
    n0 = n_pulses;
    btn_step = 1'b1;
    cycles(5);
    btn_step = 1'b0;
    cycles(30);
    chk("glitch_pulses", 32'(n_pulses - n0), 0);
    n0 = n_pulses;
    btn_step = 1'b1;
    cycles(20);
    btn_step = 1'b0;
    cycles(30);
    chk("step_pulses", 32'(n_pulses - n0), 1);
    chk("step_width", 32'(last_w), SH);
    rand_bus();
    bus.pc_out = 32'h0000_0034;
    bus.opcode = 6'h23;
    wb_pulse();
    scan_check(16);
    rand_bus();
    scan_check(32);
    bus.alu_result = 32'h0000_F00F;
    wb_pulse();
    repeat (4) begin
      page_press();
      scan_check(16);
    end
    n0 = n_pulses;
    btn_step = 1'b1;
    btn_page = 1'b1;
    cycles(14);
    btn_step = 1'b0;
    btn_page = 1'b0;
    cycles(20);
    page_m = page_m + 2'd1;
    chk("simul_pulses", 32'(n_pulses - n0), 1);
    chk("simul_width", 32'(last_w), SH);
    scan_check(16);
    repeat (6) begin
      rand_bus();
      wb_pulse();
      repeat ($urandom_range(0, 3)) page_press();
      scan_check(16);
    end
    btn_step = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.cpu_clk && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("step_seen", 32'(bus.cpu_clk), 1);
    @(posedge clk);
    #2;
    chk("step_second_high", 32'(bus.cpu_clk), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    btn_step = 1'b0;
    model_reset();
    cycles(3);
    chk_reset_state("midrst_hold");
    rst_n = 1'b1;
    n0 = n_pulses;
    cycles(40);
    chk("no_residual", 32'(n_pulses - n0), 0);
    chk("cpu_clk_low", 32'(bus.cpu_clk), 0);
    scan_check(16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
